// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the work-RAM arbiter: requester indices, the default
// starvation limit and the fixed-priority winner selection.
package mem_bus_arbiter_pkg;

    localparam int REQ_CPU        = 0;
    localparam int REQ_DMA        = 1;
    localparam int NUM_REQ        = 2;
    localparam int STARVE_DEFAULT = 4;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_CPU  = 2'd1,
        WIN_DMA  = 2'd2
    } winner_e;

    // CPU wins contention unless the DMA has waited out its full starvation budget.
    function automatic winner_e pick_winner(input logic req_cpu,
                                            input logic req_dma,
                                            input logic dma_starved);
        if (req_cpu && req_dma) begin
            return dma_starved ? WIN_DMA : WIN_CPU;
        end
        if (req_cpu) begin
            return WIN_CPU;
        end
        if (req_dma) begin
            return WIN_DMA;
        end
        return WIN_NONE;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != MAX_VAL)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single-port work RAM: CPU has fixed priority,
// the DMA gets a forced grant after STARVE contended cycles.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int STARVE = STARVE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        starve_cnt,
    output logic [7:0]        contention
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE);

    logic              req_vec   [NUM_REQ];
    logic              we_vec    [NUM_REQ];
    logic [ADDR_W-1:0] addr_vec  [NUM_REQ];
    logic [DATA_W-1:0] wdata_vec [NUM_REQ];
    logic              gnt_vec   [NUM_REQ];
    logic              rvalid_reg[NUM_REQ];

    winner_e winner;

    assign req_vec[REQ_CPU]   = req0;
    assign req_vec[REQ_DMA]   = req1;
    assign we_vec[REQ_CPU]    = we0;
    assign we_vec[REQ_DMA]    = we1;
    assign addr_vec[REQ_CPU]  = addr0;
    assign addr_vec[REQ_DMA]  = addr1;
    assign wdata_vec[REQ_CPU] = wdata0;
    assign wdata_vec[REQ_DMA] = wdata1;

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    always_comb begin
        winner = WIN_NONE;
        if (!reset) begin
            winner = pick_winner(req_vec[REQ_CPU], req_vec[REQ_DMA],
                                 starve_cnt == STARVE_LIM);
        end
    end

    always_comb begin
        gnt_vec[REQ_CPU] = 1'b0;
        gnt_vec[REQ_DMA] = 1'b0;
        case (winner)
            WIN_CPU: gnt_vec[REQ_CPU] = 1'b1;
            WIN_DMA: gnt_vec[REQ_DMA] = 1'b1;
            default: ;
        endcase
    end

    assign gnt0 = gnt_vec[REQ_CPU];
    assign gnt1 = gnt_vec[REQ_DMA];

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_vec[i]) begin
                mem_en    = 1'b1;
                mem_we    = we_vec[i];
                mem_addr  = addr_vec[i];
                mem_wdata = wdata_vec[i];
            end
        end
    end

    // One-cycle read-return strobe per requester, aligned with mem_rdata.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rvalid
            always_ff @(posedge clk) begin
                if (reset) begin
                    rvalid_reg[gi] <= 1'b0;
                end else begin
                    rvalid_reg[gi] <= gnt_vec[gi] & ~we_vec[gi];
                end
            end
        end
    endgenerate

    assign rvalid0 = rvalid_reg[REQ_CPU];
    assign rvalid1 = rvalid_reg[REQ_DMA];
    assign rdata   = mem_rdata;

    sat_counter #(
        .WIDTH (4),
        .MAX   (STARVE)
    ) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (req_vec[REQ_DMA] & ~gnt_vec[REQ_DMA]),
        .clr   (~req_vec[REQ_DMA] | gnt_vec[REQ_DMA]),
        .count (starve_cnt)
    );

    sat_counter #(
        .WIDTH (8),
        .MAX   (255)
    ) u_contention (
        .clk   (clk),
        .reset (reset),
        .inc   (req_vec[REQ_CPU] & req_vec[REQ_DMA]),
        .clr   (1'b0),
        .count (contention)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural synchronous RAM on the port.
module tb_mem_bus_arbiter;

    logic       clk;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0] starve_cnt;
    logic [7:0] contention;

    logic [7:0] tb_mem [0:255];
    logic       pre_en;
    logic [7:0] pre_addr, pre_data;

    int checks;
    int failures;

    mem_bus_arbiter #(
        .ADDR_W (8),
        .DATA_W (8),
        .STARVE (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata      (rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .starve_cnt (starve_cnt),
        .contention (contention)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model with a backdoor preload port
    always @(posedge clk) begin
        if (pre_en) begin
            tb_mem[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        logic [7:0] pa [6];
        logic [7:0] pd [6];
        pa = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h10};
        pd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h3C, 8'h00};
        @(negedge clk);
        reset = 1; req0 = 1; req1 = 1; addr0 = 8'h01; addr1 = 8'h02;
        #1;
        checks++; if (gnt0 !== 1'b0) begin failures++; $display("FAIL reset_gnt0 got=%0h exp=0", gnt0); end
        checks++; if (gnt1 !== 1'b0) begin failures++; $display("FAIL reset_gnt1 got=%0h exp=0", gnt1); end
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%0h exp=0", mem_en); end
        checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
        @(negedge clk);
        checks++; if (starve_cnt !== 4'd0) begin failures++; $display("FAIL reset_starve got=%0d exp=0", starve_cnt); end
        checks++; if (contention !== 8'd0) begin failures++; $display("FAIL reset_contention got=%0d exp=0", contention); end
        checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%0b%0b exp=00", rvalid0, rvalid1); end
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            pre_en = 1; pre_addr = pa[i]; pre_data = pd[i];
            @(negedge clk);
        end
        pre_en = 0;
        reset = 0;
        $display("reset: done, RAM preloaded");
    endtask

    task automatic test_idle();
        @(negedge clk);
        idle_inputs();
        addr0 = 8'h7F; wdata0 = 8'hFF; we0 = 1;
        #1;
        checks++; if (mem_en !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin failures++; $display("FAIL idle_grant got=%0b%0b%0b exp=000", mem_en, gnt0, gnt1); end
        checks++; if (mem_addr !== 8'h00 || mem_we !== 1'b0 || mem_wdata !== 8'h00) begin failures++; $display("FAIL idle_mux got=%0h/%0h/%0h exp=0/0/0", mem_addr, mem_we, mem_wdata); end
        idle_inputs();
        $display("idle: no request");
    endtask

    task automatic test_cpu_read();
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 8'h05;
        #1;
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin failures++; $display("FAIL cpu_read_gnt got=%0b%0b exp=10", gnt0, gnt1); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h05) begin failures++; $display("FAIL cpu_read_port got=%0b/%0b/%0h exp=1/0/05", mem_en, mem_we, mem_addr); end
        @(negedge clk);
        req0 = 0;
        checks++; if (rvalid0 !== 1'b1 || rdata !== 8'h3C) begin failures++; $display("FAIL cpu_read_data got=%0b/%0h exp=1/3c", rvalid0, rdata); end
        checks++; if (rvalid1 !== 1'b0) begin failures++; $display("FAIL cpu_read_rvalid1 got=%0b exp=0", rvalid1); end
        @(negedge clk);
        checks++; if (rvalid0 !== 1'b0) begin failures++; $display("FAIL cpu_read_pulse got=%0b exp=0", rvalid0); end
        $display("cpu read addr=05 data=%0h", 8'h3C);
    endtask

    task automatic test_dma_write();
        @(negedge clk);
        req1 = 1; we1 = 1; addr1 = 8'h10; wdata1 = 8'hA5;
        #1;
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin failures++; $display("FAIL dma_write_gnt got=%0b%0b exp=01", gnt1, gnt0); end
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'hA5) begin failures++; $display("FAIL dma_write_port got=%0b/%0h/%0h exp=1/10/a5", mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        idle_inputs();
        checks++; if (rvalid1 !== 1'b0) begin failures++; $display("FAIL dma_write_rvalid got=%0b exp=0", rvalid1); end
        req0 = 1; we0 = 0; addr0 = 8'h10;
        @(negedge clk);
        idle_inputs();
        checks++; if (rvalid0 !== 1'b1 || rdata !== 8'hA5) begin failures++; $display("FAIL dma_write_readback got=%0b/%0h exp=1/a5", rvalid0, rdata); end
        $display("dma write addr=10 data=a5, cpu readback");
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [4];
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req0 = (i < 4); we0 = 0; addr0 = 8'(i);
            #1;
            if (i < 4) begin
                checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL b2b_gnt%0d got=%0b exp=1", i, gnt0); end
            end
            if (i >= 1 && i <= 4) begin
                checks++; if (rvalid0 !== 1'b1 || rdata !== exp_d[i-1]) begin failures++; $display("FAIL b2b_data%0d got=%0b/%0h exp=1/%0h", i-1, rvalid0, rdata, exp_d[i-1]); end
                else $display("b2b read addr=%0h data=%0h", i-1, rdata);
            end
            if (i == 5) begin
                checks++; if (rvalid0 !== 1'b0) begin failures++; $display("FAIL b2b_end got=%0b exp=0", rvalid0); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic exp_g1 [10];
        logic [3:0] exp_sc [10];
        exp_g1 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        exp_sc = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        @(negedge clk);
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h01; addr1 = 8'h02;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (gnt1 !== exp_g1[i] || gnt0 !== !exp_g1[i]) begin failures++; $display("FAIL starve_gnt%0d got=%0b%0b exp=%0b%0b", i, gnt0, gnt1, !exp_g1[i], exp_g1[i]); end
            checks++; if (starve_cnt !== exp_sc[i]) begin failures++; $display("FAIL starve_cnt%0d got=%0d exp=%0d", i, starve_cnt, exp_sc[i]); end
            if (i > 0) begin
                checks++; if (rvalid1 !== exp_g1[i-1] || rvalid0 !== !exp_g1[i-1]) begin failures++; $display("FAIL starve_rvalid%0d got=%0b%0b exp=%0b%0b", i, rvalid0, rvalid1, !exp_g1[i-1], exp_g1[i-1]); end
            end
            $display("contended cycle %0d gnt0=%0b gnt1=%0b starve_cnt=%0d", i, gnt0, gnt1, starve_cnt);
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_req1_drop();
        do_reset();
        req0 = 1; req1 = 1;
        repeat (4) @(negedge clk);
        req1 = 0;
        #1;
        checks++; if (starve_cnt !== 4'd4) begin failures++; $display("FAIL drop_pre_cnt got=%0d exp=4", starve_cnt); end
        checks++; if (gnt1 !== 1'b0 || gnt0 !== 1'b1) begin failures++; $display("FAIL drop_gnt got=%0b%0b exp=10", gnt0, gnt1); end
        @(negedge clk);
        checks++; if (starve_cnt !== 4'd0) begin failures++; $display("FAIL drop_clear got=%0d exp=0", starve_cnt); end
        idle_inputs();
        $display("req1 dropped at threshold, starve_cnt cleared");
    endtask

    task automatic test_contention();
        do_reset();
        req0 = 1; req1 = 1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 254) begin
                checks++; if (contention !== 8'd254) begin failures++; $display("FAIL contention_254 got=%0d exp=254", contention); end
            end
        end
        checks++; if (contention !== 8'd255) begin failures++; $display("FAIL contention_sat got=%0d exp=255", contention); end
        $display("contention after 300 cycles=%0d", contention);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        req1 = 0; req0 = 1; we0 = 0; addr0 = 8'h05;
        @(negedge clk);
        idle_inputs();
        checks++; if (rvalid0 !== 1'b1) begin failures++; $display("FAIL midread_pending got=%0b exp=1", rvalid0); end
        reset = 1;
        @(negedge clk);
        checks++; if (rvalid0 !== 1'b0) begin failures++; $display("FAIL midread_rvalid got=%0b exp=0", rvalid0); end
        checks++; if (starve_cnt !== 4'd0 || contention !== 8'd0) begin failures++; $display("FAIL midread_counters got=%0d/%0d exp=0/0", starve_cnt, contention); end
        reset = 0;
        $display("reset mid-read: rvalid cancelled");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1;
        pre_en = 0; pre_addr = 0; pre_data = 0;
        idle_inputs();
        test_reset();
        test_idle();
        test_cpu_read();
        test_dma_write();
        test_back_to_back();
        test_starvation();
        test_req1_drop();
        test_contention();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
